// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial TX arbiter: FSM state encoding and the
// package-width helper reused by the serializer benches.
package serial_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_HI = 2'd2,
    ARB_WAIT_LO = 2'd3
  } arb_state_t;

  // Width of one serializer package: 2**aw words of ww bits.
  function automatic int pkg_width(input int aw, input int ww);
    return (2 ** aw) * ww;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_picker.sv
// Combinational round-robin picker: the search starts one past the last
// grantee and ascends with wrap-around.
module serial_rr_picker
  import serial_tx_arbiter_pkg::*;
#(
  parameter int Requesters = 4,
  parameter int IW         = $clog2(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IW-1:0]         last,
  output logic                  valid,
  output logic [IW-1:0]         winner
);

  logic [IW:0]           start;
  logic [IW:0]           pe;
  logic [IW:0]           sum;
  logic [Requesters-1:0] rot;

  always_comb begin
    start = ({1'b0, last} == (IW+1)'(Requesters - 1)) ? '0 : {1'b0, last} + 1'b1;
    // Rotate so the first candidate sits at bit 0, encode, then rotate back.
    rot = Requesters'({req, req} >> start);
    pe  = '0;
    for (int i = Requesters - 1; i >= 0; i--) begin
      if (rot[i]) pe = (IW+1)'(i);
    end
    sum = start + pe;
    if (sum >= (IW+1)'(Requesters)) sum = sum - (IW+1)'(Requesters);
    valid  = |req;
    winner = sum[IW-1:0];
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one package serializer among several sources.
// Optional SERIAL_ARB_TAG_EN stamps the winner index into the top word.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int Requesters   = 4,
  parameter int AddressWidth = 2,
  parameter int WordWidth    = 8,
  localparam int PW = pkg_width(AddressWidth, WordWidth),
  localparam int IW = $clog2(Requesters)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [Requesters-1:0]    req,
  input  logic [Requesters*PW-1:0] data,
  output logic [Requesters-1:0]    ack,
  output logic                     tx_ce,
  output logic [PW-1:0]            tx_data,
  input  logic                     tx_busy,
  output logic [IW-1:0]            grant_id,
  output logic                     active
);

  arb_state_t    state;
  logic [PW-1:0] pkg_arr [Requesters];
  logic [PW-1:0] frame;
  logic          pick_valid;
  logic [IW-1:0] pick_w;

  for (genvar i = 0; i < Requesters; i++) begin : g_unpack
    assign pkg_arr[i] = data[i*PW +: PW];
  end

`ifdef SERIAL_ARB_TAG_EN
  if (IW > WordWidth) begin : g_tag_check
    $error("serial_tx_arbiter: grant index does not fit in one word");
  end
`endif

  serial_rr_picker #(
    .Requesters(Requesters),
    .IW        (IW)
  ) u_picker (
    .req   (req),
    .last  (grant_id),
    .valid (pick_valid),
    .winner(pick_w)
  );

  always_comb begin
    frame = pkg_arr[pick_w];
`ifdef SERIAL_ARB_TAG_EN
    frame[PW-1 -: WordWidth] = WordWidth'(pick_w);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      ack      <= '0;
      tx_ce    <= 1'b0;
      tx_data  <= '0;
      grant_id <= IW'(Requesters - 1);
      active   <= 1'b0;
    end else begin
      ack   <= '0;
      tx_ce <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          // A serializer still busy (e.g. draining after reset) blocks grants.
          if (pick_valid && !tx_busy) begin
            tx_data     <= frame;
            grant_id    <= pick_w;
            ack[pick_w] <= 1'b1;
            tx_ce       <= 1'b1;
            active      <= 1'b1;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE:   state <= ARB_WAIT_HI;
        ARB_WAIT_HI: if (tx_busy) state <= ARB_WAIT_LO;
        ARB_WAIT_LO: begin
          if (!tx_busy) begin
            state  <= ARB_IDLE;
            active <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter with a behavioural serializer
// and a round-robin reference model; honours SERIAL_ARB_TAG_EN if defined.
module tb_serial_tx_arbiter;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int WW = 8;
  localparam int PW = 32;
  localparam int IW = 2;

`ifdef SERIAL_ARB_TAG_EN
  localparam logic [31:0] T1_EXP = 32'h02ADBEEF;
  localparam logic [31:0] T5_OLD = 32'h01111111;
  localparam logic [31:0] T5_NEW = 32'h01345678;
`else
  localparam logic [31:0] T1_EXP = 32'hDEADBEEF;
  localparam logic [31:0] T5_OLD = 32'h11111111;
  localparam logic [31:0] T5_NEW = 32'h12345678;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] data = '0;
  logic [N-1:0]    ack;
  logic            tx_ce;
  logic [PW-1:0]   tx_data;
  logic            tx_busy = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            active;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .Requesters  (N),
    .AddressWidth(AW),
    .WordWidth   (WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .tx_ce   (tx_ce),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .grant_id(grant_id),
    .active  (active)
  );

  int            vectors = 0;
  int            miscompares = 0;
  int            last_exp = N - 1;
  int            ser_cnt = 0;
  int            ser_len = 0;
  int            idle_cnt = 0;
  bit            rand_mode = 1'b0;
  logic [PW-1:0] ser_q = '0;
  int            grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next requester after 'last', ascending with wrap; -1 when none.
  function automatic int rr_model(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [PW-1:0] exp_frame(input int w);
    logic [PW-1:0] v;
    v = data[w*PW +: PW];
`ifdef SERIAL_ARB_TAG_EN
    v[PW-1 -: WW] = WW'(w);
`endif
    return v;
  endfunction

  // One clock: check outputs of the edge just passed, run the serializer
  // model, then (optionally) move the random requesters.
  task automatic tick();
    int   w;
    logic busy_e;
    w = -1;
    @(negedge clk);
    busy_e = tx_busy;
    if (tx_ce === 1'b1) begin
      chk("ce_not_while_busy", busy_e, 0);
      chk("ce_had_req", |req, 1);
      w = rr_model(last_exp, req);
      if (w >= 0) begin
        chk("ack_onehot", ack, 64'(1) << w);
        chk("grant_id", grant_id, w);
        chk("tx_data", tx_data, exp_frame(w));
        chk("active_in_issue", active, 1);
        last_exp = w;
        grant_log.push_back(w);
      end
      ser_q   = tx_data;
      ser_cnt = (ser_len > 0) ? ser_len : int'($urandom_range(6, 2));
      tx_busy = 1'b1;
    end else begin
      chk("ack_idle", ack, 0);
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) tx_busy = 1'b0;
      end
    end
    if (rst === 1'b1 && tx_ce !== 1'b1 && req != '0 && !busy_e) idle_cnt++;
    else idle_cnt = 0;
    chk("grant_gap", idle_cnt < 2, 1);
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (tx_ce === 1'b1 && i == w) begin
          data[i*PW +: PW] = $urandom();
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            data[i*PW +: PW] = $urandom();
            req[i] = 1'b1;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_ce(input string tag, input int max);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_ce !== 1'b1 && n < max);
    chk({tag, "_ce_seen"}, tx_ce, 1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((tx_busy || ser_cnt > 0) && n < max) begin
      tick();
      n++;
    end
    chk("drain", tx_busy, 0);
    tick();
    tick();
  endtask

  task automatic reset_dut(input logic busy_init);
    rst      = 1'b0;
    req      = '0;
    tx_busy  = busy_init;
    ser_cnt  = 0;
    last_exp = N - 1;
    idle_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_tx_ce", tx_ce, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, N - 1);
    chk("rst_active", active, 0);
    rst = 1'b1;

    // Single request from source 2
    data[2*PW +: PW] = 32'hDEADBEEF;
    req = 4'b0100;
    wait_ce("t1", 4);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_tx_data", tx_data, T1_EXP);
    chk("t1_grant_id", grant_id, 2);
    req = '0;
    tick();
    chk("t1_ce_one_cycle", tx_ce, 0);
    chk("t1_loopback_q", ser_q, T1_EXP);
    wait_idle(20);

    // Four continuous requesters for eight frames
    reset_dut(1'b0);
    for (int i = 0; i < N; i++) data[i*PW +: PW] = 32'h10000000 * (i + 1) + 32'h00A5A5A5;
    req = 4'hF;
    grant_log.delete();
    for (int f = 0; f < 8; f++) wait_ce("t3", 12);
    for (int i = 0; i < 8; i++) chk("t3_order", (i < grant_log.size()) ? grant_log[i] : -1, i % N);
    req = '0;
    wait_idle(20);

    // Serializer busy out of reset
    reset_dut(1'b1);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_no_ce", tx_ce, 0);
    end
    tx_busy = 1'b0;
    tick();
    chk("t4_grant_next", tx_ce, 1);
    chk("t4_ack", ack, 4'b0001);
    req = '0;
    wait_idle(20);

    // Data change right after ack
    reset_dut(1'b0);
    data[1*PW +: PW] = 32'h11111111;
    req = 4'b0010;
    wait_ce("t5a", 4);
    tick();
    data[1*PW +: PW] = 32'h12345678;
    chk("t5_inflight", ser_q, T5_OLD);
    wait_ce("t5b", 12);
    chk("t5_next_frame", tx_data, T5_NEW);
    req = '0;
    tick();
    chk("t5_next_q", ser_q, T5_NEW);
    wait_idle(20);

    // Asynchronous reset in WAIT_LO
    reset_dut(1'b0);
    for (int i = 0; i < N; i++) data[i*PW +: PW] = 32'hC0DE0000 + i;
    ser_len = 8;
    req = 4'hF;
    wait_ce("t6", 4);
    repeat (3) tick();
    chk("t6_active_before", active, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_tx_ce", tx_ce, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_grant_id", grant_id, N - 1);
    chk("t6_rst_active", active, 0);
    last_exp = N - 1;
    ser_cnt  = 0;
    tx_busy  = 1'b0;
    idle_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    wait_ce("t6r", 4);
    chk("t6_first_grant", grant_id, 0);
    ser_len = 0;
    req = '0;
    wait_idle(20);

`ifdef SERIAL_ARB_TAG_EN
    // Winner tag in the top word
    reset_dut(1'b0);
    data[3*PW +: PW] = 32'hAABBCCDD;
    req = 4'b1000;
    wait_ce("t7", 4);
    chk("t7_tag", tx_data, 32'h03BBCCDD);
    req = '0;
    wait_idle(20);
`endif

    // Randomized traffic against the reference model
    reset_dut(1'b0);
    rand_mode = 1'b1;
    repeat (800) tick();
    rand_mode = 1'b0;
    req = '0;
    wait_idle(20);
    chk("rand_frames", grant_log.size() > 20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
